// File: rtl/dmix_pkg.sv
// rtl/dmix_pkg.sv - shared mixer sample/gain formats and divider FSM states
package dmix_pkg;
    localparam int WD_SAMPLE = 24;
    localparam int WS_GAIN   = 16;
    localparam int FRAC_GAIN = 15;
    localparam logic [WS_GAIN-1:0] Q15_ONE = 16'h7FFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } dmix_state_e;
endpackage

// File: rtl/divemu_sat.sv
// rtl/divemu_sat.sv - clip an unsigned quotient magnitude plus sign to a signed WD-bit result
module divemu_sat #(
    parameter int WD = 24,
    parameter int WM = 39
) (
    input  logic [WM-1:0] mag,
    input  logic          neg,
    output logic [WD-1:0] res,
    output logic          sat
);
    localparam logic [WM-1:0] POS_MAX = {{(WM-WD+1){1'b0}}, {(WD-1){1'b1}}};
    localparam logic [WM-1:0] NEG_MAX = POS_MAX + WM'(1);

    always_comb begin
        res = '0;
        sat = 1'b0;
        if (neg) begin
            if (mag > NEG_MAX) begin
                res = {1'b1, {(WD-1){1'b0}}};
                sat = 1'b1;
            end else begin
                // magnitude 2^(WD-1) negates onto itself, the exact minimum
                res = -mag[WD-1:0];
            end
        end else if (mag > POS_MAX) begin
            res = {1'b0, {(WD-1){1'b1}}};
            sat = 1'b1;
        end else begin
            res = mag[WD-1:0];
        end
    end
endmodule

// File: rtl/divemu.sv
// rtl/divemu.sv - iterative signed divider: quot = (dividend << FRAC) / divisor, one bit per clock
module divemu
    import dmix_pkg::*;
#(
    parameter int WD   = WD_SAMPLE,
    parameter int WS   = WS_GAIN,
    parameter int FRAC = FRAC_GAIN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [WD-1:0] dividend_i,
    input  logic [WS-1:0] divisor_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WD-1:0] quot_o,
    output logic          sat_o,
    output logic          dbz_o
);
    localparam int NITER = WD + FRAC;
    localparam int CW    = $clog2(NITER + 1);

    dmix_state_e       state;
    logic [NITER-1:0]  num;
    logic [WS-1:0]     rem;
    logic [WS:0]       dvs;
    logic [CW-1:0]     cnt;
    logic              neg;
    logic              dbz_r;
    logic              nz;

    logic [WD-1:0]     dvd_mag;
    logic [WS-1:0]     dvs_mag;
    logic [WS:0]       trial;
    logic [WS:0]       diff;
    logic              fit;
    logic [NITER-1:0]  sat_mag;
    logic [WD-1:0]     sat_res;
    logic              sat_flag;

    assign dvd_mag = dividend_i[WD-1] ? -dividend_i : dividend_i;
    assign dvs_mag = divisor_i[WS-1] ? -divisor_i : divisor_i;

    // remainder stays below the divisor, so the shifted trial fits WS+1 bits
    assign trial = {rem, num[NITER-1]};
    assign diff  = trial - dvs;
    assign fit   = trial >= dvs;

    // a zero divisor is routed through the clipper as an infinite magnitude
    assign sat_mag = dbz_r ? {NITER{nz}} : num;

    divemu_sat #(.WD(WD), .WM(NITER)) u_sat (
        .mag (sat_mag),
        .neg (neg),
        .res (sat_res),
        .sat (sat_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            quot_o    <= '0;
            sat_o     <= 1'b0;
            dbz_o     <= 1'b0;
            num       <= '0;
            rem       <= '0;
            dvs       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            dbz_r     <= 1'b0;
            nz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        num      <= {dvd_mag, {FRAC{1'b0}}};
                        dvs      <= {1'b0, dvs_mag};
                        rem      <= '0;
                        cnt      <= '0;
                        neg      <= dividend_i[WD-1] ^ divisor_i[WS-1];
                        dbz_r    <= (divisor_i == '0);
                        nz       <= (dividend_i != '0);
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CALC: begin
                    if (dbz_r || cnt == CW'(NITER)) begin
                        quot_o    <= sat_res;
                        sat_o     <= sat_flag;
                        dbz_o     <= dbz_r;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rem <= fit ? diff[WS-1:0] : trial[WS-1:0];
                        num <= {num[NITER-2:0], fit};
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_divemu.sv
// tb/tb_divemu.sv - self-checking bench for divemu against a 64-bit integer division model
module tb_divemu;
    import dmix_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] quot_o;
    logic        sat_o;
    logic        dbz_o;

    int checks = 0;
    int failures = 0;

    divemu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quot_o     (quot_o),
        .sat_o      (sat_o),
        .dbz_o      (dbz_o)
    );

    always #5 clk = ~clk;

    // reference: exact signed division of dividend*2^15, truncating toward zero, then clipping
    function automatic void model(input logic [23:0] a, input logic [15:0] b,
                                  output logic [23:0] q, output logic s, output logic z);
        longint n, d, r;
        n = longint'($signed(a)) * 32768;
        d = longint'($signed(b));
        if (d == 0) begin
            z = 1'b1;
            if (n > 0)      begin q = 24'h7FFFFF; s = 1'b1; end
            else if (n < 0) begin q = 24'h800000; s = 1'b1; end
            else            begin q = 24'h000000; s = 1'b0; end
        end else begin
            z = 1'b0;
            r = n / d;
            if (r > 64'sd8388607)       begin q = 24'h7FFFFF; s = 1'b1; end
            else if (r < -64'sd8388608) begin q = 24'h800000; s = 1'b1; end
            else                        begin q = r[23:0];    s = 1'b0; end
        end
    endfunction

    task automatic run_op(input logic [23:0] a, input logic [15:0] b, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, quot_o, sat_o, dbz_o} !== 28'd0) begin
            failures++;
            $display("FAIL reset_state: rdy=%b vld=%b q=%h sat=%b dbz=%b required all zero",
                     in_ready, out_valid, quot_o, sat_o, dbz_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [23:0] da [12];
        logic [15:0] db [12];
        logic [23:0] eq [12];
        logic        es [12];
        logic        ez [12];
        int          el [12];
        int          lat;
        da = '{24'h000004, 24'h000018, 24'hFE0004, 24'h000001, 24'hFFFFFF, 24'h100000,
               24'hFFFFFB, 24'h000000, 24'hFFFF00, 24'h000100, 24'h800000, 24'h123456};
        db = '{16'd2, 16'd4, 16'h7FFF, 16'd3, 16'd3, 16'd1,
               16'd0, 16'd0, 16'd1, 16'd1, 16'h8000, Q15_ONE};
        eq = '{24'h010000, 24'h030000, 24'hFE0000, 24'h002AAA, 24'hFFD556, 24'h7FFFFF,
               24'h800000, 24'h000000, 24'h800000, 24'h7FFFFF, 24'h7FFFFF, 24'h12347A};
        es = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        ez = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        el = '{40, 40, 40, 40, 40, 40, 1, 1, 40, 40, 40, 40};
        for (int i = 0; i < 12; i++) begin
            run_op(da[i], db[i], lat);
            checks++;
            if (lat !== el[i] || quot_o !== eq[i] || sat_o !== es[i] || dbz_o !== ez[i]) begin
                failures++;
                $display("FAIL directed_%0d: lat=%0d q=%h sat=%b dbz=%b required lat=%0d q=%h sat=%b dbz=%b",
                         i, lat, quot_o, sat_o, dbz_o, el[i], eq[i], es[i], ez[i]);
            end
            finish_op();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || quot_o !== eq[i]) begin
                failures++;
                $display("FAIL directed_after_hs_%0d: vld=%b rdy=%b q=%h required 0 1 %h",
                         i, out_valid, in_ready, quot_o, eq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(24'h000018, 16'd4, lat);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot_o !== 24'h030000 ||
                sat_o !== 1'b0 || dbz_o !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold_%0d: vld=%b rdy=%b q=%h required 1 0 030000",
                         i, out_valid, in_ready, quot_o);
            end
            @(posedge clk); #1;
        end
        finish_op();
        run_op(24'h000004, 16'd2, lat);
        checks++;
        if (lat !== 40 || quot_o !== 24'h010000) begin
            failures++;
            $display("FAIL backpressure_next: lat=%0d q=%h required 40 010000", lat, quot_o);
        end
        finish_op();
    endtask

    task automatic test_busy_ignore();
        int lat;
        run_op(24'h000001, 16'd3, lat);
        finish_op();
        dividend = 24'h000018;
        divisor  = 16'd4;
        in_valid = 1'b1;
        @(posedge clk); #1;
        dividend = 24'h100000;
        divisor  = 16'd1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL busy_ready_%0d: in_ready=%b required 0", lat, in_ready);
            end
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat !== 40 || quot_o !== 24'h030000 || sat_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_result: lat=%0d q=%h sat=%b required 40 030000 0", lat, quot_o, sat_o);
        end
        finish_op();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL no_accept_at_hs_%0d: vld=%b rdy=%b required 0 1", i, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        while (!in_ready) begin
            @(posedge clk); #1;
        end
        dividend = 24'h000004;
        divisor  = 16'd2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, quot_o, sat_o, dbz_o} !== 28'd0) begin
            failures++;
            $display("FAIL reset_mid_state: rdy=%b vld=%b q=%h required all zero", in_ready, out_valid, quot_o);
        end
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_discard: valid_cycles=%0d rdy=%b required 0 1", seen, in_ready);
        end
    endtask

    task automatic test_random();
        logic [23:0] a, eq;
        logic [15:0] b;
        logic        es, ez;
        int          lat, el, bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: a = 24'($urandom);
                1: a = 24'($signed($urandom_range(0, 2000)) - 1000);
                2: a = $urandom_range(0, 1) ? 24'h800000 : 24'h7FFFFF;
                default: a = 24'($signed($urandom_range(0, 1024)) - 512);
            endcase
            case ($urandom_range(0, 4))
                0: b = 16'($urandom);
                1: b = 16'd0;
                2: b = 16'($signed($urandom_range(0, 16)) - 8);
                3: b = $urandom_range(0, 1) ? 16'h8000 : 16'h7FFF;
                default: b = 16'($urandom_range(0, 32767));
            endcase
            model(a, b, eq, es, ez);
            el = ez ? 1 : 40;
            run_op(a, b, lat);
            checks++;
            if (lat !== el || quot_o !== eq || sat_o !== es || dbz_o !== ez) begin
                failures++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_%0d a=%h b=%h: lat=%0d q=%h sat=%b dbz=%b required lat=%0d q=%h sat=%b dbz=%b",
                             i, a, b, lat, quot_o, sat_o, dbz_o, el, eq, es, ez);
            end
            finish_op();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
